// File: rtl/axis_frame_len_stats.sv
// Frame-length statistics accumulator fed by the frame_len/frame_len_valid strobe.
// Keeps saturating totals, min/max/last length and runt/oversize counts for CSR readout.
module axis_frame_len_stats #(
   parameter int LEN_WIDTH        = 16,
   parameter int COUNT_WIDTH      = 32,
   parameter int BYTE_COUNT_WIDTH = 48,
   parameter int MIN_LEN          = 64,
   parameter int MAX_LEN          = 1518
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LEN_WIDTH-1:0]        frame_len,
   input  logic                        frame_len_valid,
   input  logic                        stat_clear,
   output logic [COUNT_WIDTH-1:0]      stat_frame_count,
   output logic [BYTE_COUNT_WIDTH-1:0] stat_byte_count,
   output logic [LEN_WIDTH-1:0]        stat_min_len,
   output logic [LEN_WIDTH-1:0]        stat_max_len,
   output logic [LEN_WIDTH-1:0]        stat_last_len,
   output logic [COUNT_WIDTH-1:0]      stat_runt_count,
   output logic [COUNT_WIDTH-1:0]      stat_oversize_count,
   output logic                        stat_valid,
   output logic                        stat_update
);

   // Sum width covers either operand plus a carry bit, so the clamp also works when LEN_WIDTH > BYTE_COUNT_WIDTH.
   localparam int SUM_W = ((BYTE_COUNT_WIDTH > LEN_WIDTH) ? BYTE_COUNT_WIDTH : LEN_WIDTH) + 1;
   localparam logic [BYTE_COUNT_WIDTH-1:0] BYTE_MAX = '1;
   localparam logic [LEN_WIDTH-1:0]        MIN_L    = LEN_WIDTH'(MIN_LEN);
   localparam logic [LEN_WIDTH-1:0]        MAX_L    = LEN_WIDTH'(MAX_LEN);

   logic [COUNT_WIDTH-1:0]      frame_cnt_q, frame_cnt_d;
   logic [COUNT_WIDTH-1:0]      runt_cnt_q, runt_cnt_d;
   logic [COUNT_WIDTH-1:0]      over_cnt_q, over_cnt_d;
   logic [BYTE_COUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
   logic [LEN_WIDTH-1:0]        min_len_q, min_len_d;
   logic [LEN_WIDTH-1:0]        max_len_q, max_len_d;
   logic [LEN_WIDTH-1:0]        last_len_q, last_len_d;
   logic                        valid_q, valid_d;
   logic                        update_q, update_d;
   logic [SUM_W-1:0]            byte_sum;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      runt_cnt_d  = runt_cnt_q;
      over_cnt_d  = over_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      min_len_d   = min_len_q;
      max_len_d   = max_len_q;
      last_len_d  = last_len_q;
      valid_d     = valid_q;
      update_d    = frame_len_valid;
      byte_sum    = '0;

      // Clear first, then apply any same-cycle frame on top so stats restart from it.
      if (stat_clear) begin
         frame_cnt_d = '0;
         runt_cnt_d  = '0;
         over_cnt_d  = '0;
         byte_cnt_d  = '0;
         min_len_d   = '1;
         max_len_d   = '0;
         valid_d     = 1'b0;
      end

      if (frame_len_valid) begin
         frame_cnt_d = sat_inc(frame_cnt_d);
         byte_sum    = SUM_W'(byte_cnt_d) + SUM_W'(frame_len);
         byte_cnt_d  = (byte_sum > SUM_W'(BYTE_MAX)) ? BYTE_MAX : byte_sum[BYTE_COUNT_WIDTH-1:0];
         last_len_d  = frame_len;
         if (frame_len < min_len_d) min_len_d = frame_len;
         if (frame_len > max_len_d) max_len_d = frame_len;
         if (frame_len < MIN_L) runt_cnt_d = sat_inc(runt_cnt_d);
         if (frame_len > MAX_L) over_cnt_d = sat_inc(over_cnt_d);
         valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         runt_cnt_q  <= '0;
         over_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         min_len_q   <= '1;
         max_len_q   <= '0;
         last_len_q  <= '0;
         valid_q     <= 1'b0;
         update_q    <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         runt_cnt_q  <= runt_cnt_d;
         over_cnt_q  <= over_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         min_len_q   <= min_len_d;
         max_len_q   <= max_len_d;
         last_len_q  <= last_len_d;
         valid_q     <= valid_d;
         update_q    <= update_d;
      end
   end

   assign stat_frame_count    = frame_cnt_q;
   assign stat_byte_count     = byte_cnt_q;
   assign stat_min_len        = min_len_q;
   assign stat_max_len        = max_len_q;
   assign stat_last_len       = last_len_q;
   assign stat_runt_count     = runt_cnt_q;
   assign stat_oversize_count = over_cnt_q;
   assign stat_valid          = valid_q;
   assign stat_update         = update_q;

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed and randomised checks of axis_frame_len_stats, plus a narrow-counter
// instance for saturation.
module tb_axis_frame_len_stats;

   logic        clk;
   logic        rst;
   logic [15:0] frame_len;
   logic        frame_len_valid;
   logic        stat_clear;
   logic [31:0] fc, rc, oc;
   logic [47:0] bc;
   logic [15:0] mn, mx, ls;
   logic        sv, su;

   logic [15:0] s_len;
   logic        s_valid;
   logic        s_clear;
   logic [3:0]  s_fc, s_rc, s_oc;
   logic [11:0] s_bc;
   logic [15:0] s_mn, s_mx, s_ls;
   logic        s_sv, s_su;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_fc, m_bc, m_rc, m_oc, m_mn, m_mx, m_ls;
   int          ev_n;
   logic        drive_v;
   logic [15:0] drive_l;

   axis_frame_len_stats dut (
      .clk(clk), .rst(rst), .frame_len(frame_len), .frame_len_valid(frame_len_valid),
      .stat_clear(stat_clear), .stat_frame_count(fc), .stat_byte_count(bc),
      .stat_min_len(mn), .stat_max_len(mx), .stat_last_len(ls),
      .stat_runt_count(rc), .stat_oversize_count(oc), .stat_valid(sv), .stat_update(su)
   );

   axis_frame_len_stats #(.COUNT_WIDTH(4), .BYTE_COUNT_WIDTH(12)) dut_sat (
      .clk(clk), .rst(rst), .frame_len(s_len), .frame_len_valid(s_valid),
      .stat_clear(s_clear), .stat_frame_count(s_fc), .stat_byte_count(s_bc),
      .stat_min_len(s_mn), .stat_max_len(s_mx), .stat_last_len(s_ls),
      .stat_runt_count(s_rc), .stat_oversize_count(s_oc), .stat_valid(s_sv), .stat_update(s_su)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [63:0] e_fc, input logic [63:0] e_bc,
                          input logic [63:0] e_mn, input logic [63:0] e_mx, input logic [63:0] e_ls,
                          input logic [63:0] e_rc, input logic [63:0] e_oc,
                          input logic [63:0] e_sv, input logic [63:0] e_su);
      chk({tag, ".frame_count"}, 64'(fc), e_fc);
      chk({tag, ".byte_count"},  64'(bc), e_bc);
      chk({tag, ".min_len"},     64'(mn), e_mn);
      chk({tag, ".max_len"},     64'(mx), e_mx);
      chk({tag, ".last_len"},    64'(ls), e_ls);
      chk({tag, ".runt"},        64'(rc), e_rc);
      chk({tag, ".oversize"},    64'(oc), e_oc);
      chk({tag, ".valid"},       64'(sv), e_sv);
      chk({tag, ".update"},      64'(su), e_su);
   endtask

   // Called at a falling edge; returns at the next falling edge with the event visible.
   task automatic send(input logic [15:0] l);
      frame_len       = l;
      frame_len_valid = 1'b1;
      @(negedge clk);
      frame_len_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic model_event(input logic [15:0] l);
      m_fc = (m_fc == 64'hFFFF_FFFF) ? m_fc : m_fc + 1;
      m_bc = (m_bc + 64'(l) > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : m_bc + 64'(l);
      m_ls = 64'(l);
      if (64'(l) < m_mn) m_mn = 64'(l);
      if (64'(l) > m_mx) m_mx = 64'(l);
      if (l < 16'd64)   m_rc = (m_rc == 64'hFFFF_FFFF) ? m_rc : m_rc + 1;
      if (l > 16'd1518) m_oc = (m_oc == 64'hFFFF_FFFF) ? m_oc : m_oc + 1;
   endtask

   initial begin
      rst = 1'b1; frame_len = '0; frame_len_valid = 1'b0; stat_clear = 1'b0;
      s_len = '0; s_valid = 1'b0; s_clear = 1'b0;
      repeat (2) @(negedge clk);
      chk_all("reset", 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
      chk("reset.sat_min", 64'(s_mn), 16'hFFFF);
      rst = 1'b0;
      @(negedge clk);

      send(16'd100);
      chk_all("first", 1, 100, 100, 100, 100, 0, 0, 1, 1);
      @(negedge clk);
      chk("first.update_drop", 64'(su), 0);

      do_reset();
      frame_len_valid = 1'b1;
      frame_len = 16'd60;   @(negedge clk);
      frame_len = 16'd1518; @(negedge clk);
      frame_len = 16'd1519; @(negedge clk);
      frame_len = 16'd0;    @(negedge clk);
      frame_len_valid = 1'b0;
      chk_all("b2b", 4, 3097, 0, 1519, 0, 2, 1, 1, 1);

      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      chk_all("clear", 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);

      stat_clear = 1'b1;
      send(16'd200);
      stat_clear = 1'b0;
      chk_all("clr_ev", 1, 200, 200, 200, 200, 0, 0, 1, 1);

      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      chk_all("clr_hold_last", 0, 0, 16'hFFFF, 0, 200, 0, 0, 0, 0);

      stat_clear = 1'b1;
      send(16'd10);
      stat_clear = 1'b0;
      chk_all("clr_ev_runt", 1, 10, 10, 10, 10, 1, 0, 1, 1);

      send(16'd700);
      send(16'd2000);
      rst = 1'b1;
      send(16'd500);
      rst = 1'b0;
      chk_all("rst_ev", 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);

      s_valid = 1'b1; s_len = 16'd300;
      repeat (20) @(negedge clk);
      chk("sat.frame_count", 64'(s_fc), 15);
      chk("sat.byte_count",  64'(s_bc), 4095);
      chk("sat.min_len",     64'(s_mn), 300);
      repeat (3) @(negedge clk);
      s_valid = 1'b0;
      chk("sat.frame_hold", 64'(s_fc), 15);
      chk("sat.byte_hold",  64'(s_bc), 4095);
      s_valid = 1'b1; s_len = 16'd0;
      repeat (17) @(negedge clk);
      s_valid = 1'b0;
      chk("sat.runt", 64'(s_rc), 15);
      chk("sat.frame_after_runts", 64'(s_fc), 15);

      do_reset();
      m_fc = 0; m_bc = 0; m_rc = 0; m_oc = 0; m_mn = 64'hFFFF; m_mx = 0; m_ls = 0;
      ev_n = 0;
      while (ev_n < 1000) begin
         drive_v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       drive_l = 16'($urandom_range(0, 70));
            1:       drive_l = 16'($urandom_range(1510, 1530));
            default: drive_l = 16'($urandom_range(0, 9000));
         endcase
         frame_len       = drive_l;
         frame_len_valid = drive_v;
         if (drive_v) begin
            model_event(drive_l);
            ev_n++;
         end
         @(negedge clk);
         if (drive_v)
            chk_all("rand", m_fc, m_bc, m_mn, m_mx, m_ls, m_rc, m_oc, 1, 1);
         else
            chk("rand.idle_update", 64'(su), 0);
      end
      frame_len_valid = 1'b0;
      @(negedge clk);
      chk("rand.final_count", 64'(fc), 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_frame_len_stats.md
Name: axis_frame_len_stats

Overview:
Frame-length statistics accumulator that consumes the frame_len / frame_len_valid status stream of the frame length measurement stage. It sits directly downstream of that stage in MAC/monitor datapaths. Per measured frame it updates:
- frame and byte totals
- min/max length
- runt and oversize counts
- last length

It supports a synchronous clear. The resulting counters feed CSR readout.

Parameters:
LEN_WIDTH, 16, width of frame_len input and of min/max/last registers
COUNT_WIDTH, 32, width of frame, runt and oversize counters
BYTE_COUNT_WIDTH, 48, width of byte total accumulator
MIN_LEN, 64, frames with length strictly below this count as runt
MAX_LEN, 1518, frames with length strictly above this count as oversize

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
frame_len  input  LEN_WIDTH  measured frame length, qualified by frame_len_valid
frame_len_valid  input  1  single-cycle strobe, one per completed frame
stat_clear  input  1  single-cycle synchronous clear of all statistics
stat_frame_count  output  COUNT_WIDTH  frames seen since clear
stat_byte_count  output  BYTE_COUNT_WIDTH  sum of frame_len since clear
stat_min_len  output  LEN_WIDTH  smallest length since clear
stat_max_len  output  LEN_WIDTH  largest length since clear
stat_last_len  output  LEN_WIDTH  most recent frame length
stat_runt_count  output  COUNT_WIDTH  frames with len < MIN_LEN
stat_oversize_count  output  COUNT_WIDTH  frames with len > MAX_LEN
stat_valid  output  1  high once at least one frame is accumulated since clear/reset
stat_update  output  1  one-cycle pulse; outputs changed this cycle due to a frame

Behaviour:
- Reset values:
  - all counts, stat_max_len, stat_last_len = 0
  - stat_min_len = all ones
  - stat_valid = 0, stat_update = 0
- Input has no backpressure. Every cycle with frame_len_valid=1 is one frame event. Back-to-back strobes on consecutive cycles must each be counted.
- Latency: a frame event in cycle N is reflected on all outputs from cycle N+1. stat_update is high in cycle N+1 only.
- On a frame event with length L:
  - frame_count += 1
  - byte_count += L, with L zero-extended
  - last_len = L
  - min_len = min(min_len, L)
  - max_len = max(max_len, L)
  - runt_count += 1 if L < MIN_LEN
  - oversize_count += 1 if L > MAX_LEN
  - stat_valid = 1
- L = 0 is a legal event (tlast with no valid bytes). It counts as a frame and as a runt, and sets min_len = 0.
- Saturation: every counter and the byte accumulator saturate at all-ones and never wrap. The sum is computed one bit wider and clamped.
- Clear only (stat_clear=1, no event): next cycle all outputs return to reset values, except stat_last_len, which is held. stat_update = 0.
- Clear with a simultaneous event: statistics restart from that single frame:
  - frame_count = 1
  - byte_count = L
  - min = max = last = L
  - runt/oversize = 0 or 1 according to L
  - stat_valid = 1, stat_update = 1
- rst has priority over stat_clear and frame events. rst asserted during an event cycle discards the event.
- No FSM states beyond stat_valid. All state is in registered accumulators updated from a single next-state combinational block.

Test Plan:
- Reset, then event L=100 -> next cycle: frame_count=1, byte_count=100, min=max=last=100, runt=0, oversize=0, stat_valid=1, stat_update pulse of exactly 1 cycle.
- Back-to-back events L=60, 1518, 1519, 0 on consecutive cycles -> frame_count=4, byte_count=3097, min=0, max=1519, last=0, runt=2, oversize=1.
- stat_clear alone after above -> counts=0, max=0, min=0xFFFF, stat_valid=0, last=0 retained, no stat_update; then stat_clear with simultaneous event L=200 -> frame_count=1, byte_count=200, min=max=200.
- Saturation with COUNT_WIDTH=4, BYTE_COUNT_WIDTH=12: 20 events of L=300 -> frame_count=15, byte_count=4095, no wrap on further events.
- rst asserted in the same cycle as an event L=500 -> all outputs at reset values next cycle; event not counted.
- Random gaps/bursts of 1000 events vs scoreboard model -> all outputs match after every stat_update.
